// File: rtl/ahb_arbiter2.sv
// Two-master AHB-lite arbiter: buffers each master's address phase and replays it to one slave as SINGLE.
// Latency: address accepted in cycle T -> slave address phase T+2 -> slave data phase T+3.
// Backpressure: a master with a buffered request sees hreadyout=0 until its own slave data phase completes.
module ahb_arbiter2 #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [1:0]        m0_htrans_i,
  input  logic              m0_hwrite_i,
  input  logic [2:0]        m0_hsize_i,
  input  logic [2:0]        m0_hburst_i,
  input  logic [AWIDTH-1:0] m0_haddr_i,
  input  logic [DWIDTH-1:0] m0_hwdata_i,
  output logic              m0_hreadyout_o,
  output logic              m0_hresp_o,
  output logic [DWIDTH-1:0] m0_hrdata_o,
  input  logic [1:0]        m1_htrans_i,
  input  logic              m1_hwrite_i,
  input  logic [2:0]        m1_hsize_i,
  input  logic [2:0]        m1_hburst_i,
  input  logic [AWIDTH-1:0] m1_haddr_i,
  input  logic [DWIDTH-1:0] m1_hwdata_i,
  output logic              m1_hreadyout_o,
  output logic              m1_hresp_o,
  output logic [DWIDTH-1:0] m1_hrdata_o,
  output logic [1:0]        s_htrans_o,
  output logic              s_hwrite_o,
  output logic [2:0]        s_hsize_o,
  output logic [2:0]        s_hburst_o,
  output logic [AWIDTH-1:0] s_haddr_o,
  output logic [DWIDTH-1:0] s_hwdata_o,
  output logic              s_hready_o,
  input  logic              s_hready_i,
  input  logic              s_hresp_i,
  input  logic [DWIDTH-1:0] s_hrdata_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic              write;
    logic [2:0]        size;
  } abuf_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   pend0_q, pend0_d;
  logic   pend1_q, pend1_d;
  abuf_t  buf0_q, buf0_d;
  abuf_t  buf1_q, buf1_d;

  logic   in_data;
  logic   done;
  logic   rdy0;
  logic   rdy1;
  logic   cap0;
  logic   cap1;
  abuf_t  gbuf;

  // Burst type and the SEQ/NONSEQ distinction do not matter: every transfer is replayed as SINGLE.
  logic   unused_ok;
  assign unused_ok = ^{m0_hburst_i, m1_hburst_i, m0_htrans_i[0], m1_htrans_i[0]};

  // Ready/capture decode: a master is free when it has nothing buffered or its transfer completes now.
  always_comb begin
    in_data = (state_q == ST_DATA);
    done    = in_data && s_hready_i;
    rdy0    = !pend0_q || (done && !grant_q);
    rdy1    = !pend1_q || (done && grant_q);
    cap0    = rdy0 && m0_htrans_i[1];
    cap1    = rdy1 && m1_htrans_i[1];
  end

  // Request buffers: a new capture in the completion cycle wins over the clear.
  always_comb begin
    pend0_d = pend0_q;
    pend1_d = pend1_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (done && !grant_q) pend0_d = 1'b0;
    if (done && grant_q)  pend1_d = 1'b0;
    if (cap0) begin
      pend0_d = 1'b1;
      buf0_d  = '{addr: m0_haddr_i, write: m0_hwrite_i, size: m0_hsize_i};
    end
    if (cap1) begin
      pend1_d = 1'b1;
      buf1_d  = '{addr: m1_haddr_i, write: m1_hwrite_i, size: m1_hsize_i};
    end
  end

  // Arbitration FSM next state: grant is decided in IDLE, one address cycle, then wait out the data phase.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pend0_q || pend1_q) begin
          state_d = ST_ADDR;
          if (pend0_q && pend1_q) begin
            grant_d = (PRIO_MODE != 0) ? 1'b0 : !last_grant_q;
          end else begin
            grant_d = pend1_q;
          end
          last_grant_d = grant_d;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: if (s_hready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight without reporting completion.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  // Slave-side and master-side outputs; response paths are combinational from the slave.
  always_comb begin
    gbuf           = grant_q ? buf1_q : buf0_q;
    s_htrans_o     = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    s_haddr_o      = gbuf.addr;
    s_hwrite_o     = gbuf.write;
    s_hsize_o      = gbuf.size;
    s_hburst_o     = 3'b000;
    s_hwdata_o     = grant_q ? m1_hwdata_i : m0_hwdata_i;
    s_hready_o     = in_data ? s_hready_i : 1'b1;
    m0_hreadyout_o = rdy0;
    m1_hreadyout_o = rdy1;
    m0_hresp_o     = in_data && !grant_q && s_hresp_i;
    m1_hresp_o     = in_data && grant_q && s_hresp_i;
    m0_hrdata_o    = (in_data && !grant_q) ? s_hrdata_i : '0;
    m1_hrdata_o    = (in_data && grant_q) ? s_hrdata_i : '0;
  end

endmodule
